// File: rtl/piso_bit_streamer.sv
// Parallel-in/serial-out word streamer: shifts WIDTH-bit words out MSB-first on bit_en ticks,
// with GAP idle bit periods between words. Define PISO_PARITY_EN to append an even-parity bit.
module piso_bit_streamer #(
   parameter int WIDTH = 8,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             data_out,
   output logic             data_valid,
   output logic             busy,
   output logic             word_done
);

`ifdef PISO_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif
   localparam int CW = $clog2(NB);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(NB - 1);
   localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {StIdle, StShift, StGap} state_t;

   state_t        state;
   logic [NB-2:0] rest;      // bits still to be shown after the one on data_out
   logic [CW-1:0] bit_cnt;
   logic [GW-1:0] gap_cnt;
   logic [NB-1:0] load_word;
   logic          last_tick;
   logic          xfer;

`ifdef PISO_PARITY_EN
   assign load_word = {in_data, ^in_data};
`else
   assign load_word = in_data;
`endif

   assign last_tick = (state == StShift) && bit_en && (bit_cnt == LAST_BIT);
   assign in_ready  = (state == StIdle) || ((GAP == 0) && last_tick);
   assign xfer      = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         rest       <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         data_out   <= 1'b0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         word_done  <= 1'b0;
      end else begin
         word_done <= 1'b0;
         if (xfer) begin
            // Covers both the idle accept and the gapless reload on the final-bit edge.
            state      <= StShift;
            rest       <= load_word[NB-2:0];
            data_out   <= load_word[NB-1];
            bit_cnt    <= '0;
            data_valid <= 1'b1;
            busy       <= 1'b1;
            word_done  <= last_tick;
         end else begin
            unique case (state)
               StIdle: begin
               end
               StShift: begin
                  if (bit_en) begin
                     if (bit_cnt == LAST_BIT) begin
                        word_done  <= 1'b1;
                        data_out   <= 1'b0;
                        data_valid <= 1'b0;
                        if (GAP > 0) begin
                           state   <= StGap;
                           gap_cnt <= '0;
                        end else begin
                           state <= StIdle;
                           busy  <= 1'b0;
                        end
                     end else begin
                        data_out <= rest[NB-2];
                        rest     <= rest << 1;
                        bit_cnt  <= bit_cnt + CW'(1);
                     end
                  end
               end
               StGap: begin
                  if (bit_en) begin
                     if (gap_cnt == LAST_GAP) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                     end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                     end
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_piso_bit_streamer.sv
// Bench for piso_bit_streamer: a GAP=0 and a GAP=3 instance, directed and random words,
// every output checked each cycle against an expected-bit queue plus a gap countdown.
module tb_piso_bit_streamer;

   localparam int W  = 8;
   localparam int NI = 2;
   localparam int QN = 4096;
`ifdef PISO_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic         clk;
   logic         rst_n;
   logic         bit_en;
   logic         in_valid   [NI];
   logic [W-1:0] in_data    [NI];
   logic         in_ready   [NI];
   logic         data_out   [NI];
   logic         data_valid [NI];
   logic         busy       [NI];
   logic         word_done  [NI];

   piso_bit_streamer #(.WIDTH(W), .GAP(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .in_valid(in_valid[0]), .in_data(in_data[0]),
      .in_ready(in_ready[0]), .data_out(data_out[0]), .data_valid(data_valid[0]),
      .busy(busy[0]), .word_done(word_done[0])
   );

   piso_bit_streamer #(.WIDTH(W), .GAP(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .in_valid(in_valid[1]), .in_data(in_data[1]),
      .in_ready(in_ready[1]), .data_out(data_out[1]), .data_valid(data_valid[1]),
      .busy(busy[1]), .word_done(word_done[1])
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [1:0] sb_mem [NI][QN];  // {expected bit, last bit of word}
   int         sb_wr [NI];
   int         sb_rd [NI];
   int         gap_rem [NI];
   int         retired [NI];
   logic       wd_exp [NI];
   int         bit_mode = 0;
   int         cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int gap_of(input int k);
      return (k == 0) ? 0 : 3;
   endfunction

   function automatic void check(input string name, input int k, input logic act,
                                 input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d: got %b expected %b at %0t", name, k, act, exp, $time);
      end
   endfunction

   function automatic void timeout_fail(input string name, input int k);
      n_cmp++;
      n_bad++;
      $display("FAIL %s inst%0d: timed out at %0t", name, k, $time);
   endfunction

   function automatic void push_word(input int k, input logic [W-1:0] d);
      for (int i = W - 1; i >= 0; i--) begin
         sb_mem[k][sb_wr[k] % QN] = {d[i], (i == 0 && PAR == 0)};
         sb_wr[k]++;
      end
      if (PAR != 0) begin
         sb_mem[k][sb_wr[k] % QN] = {^d, 1'b1};
         sb_wr[k]++;
      end
   endfunction

   // bit_en pacing: 0 = every clock, 1 = every third clock, 2 = random
   initial begin
      bit_en = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (bit_mode)
            0:       bit_en = 1'b1;
            1:       bit_en = (cyc % 3 == 0);
            default: bit_en = ($urandom_range(0, 1) != 0);
         endcase
      end
   end

   // Monitor / reference model: a word becomes a queue of bits; each bit_en tick retires the
   // head bit; after a word's last bit GAP more ticks must pass before the block is idle.
   initial begin
      logic       have;
      logic [1:0] fr;
      logic       exp_rdy;
      logic       xfer;
      for (int k = 0; k < NI; k++) begin
         sb_wr[k] = 0; sb_rd[k] = 0; gap_rem[k] = 0; retired[k] = 0; wd_exp[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
               sb_wr[k] = 0; sb_rd[k] = 0; gap_rem[k] = 0; wd_exp[k] = 1'b0;
               check("rst_data_out", k, data_out[k], 1'b0);
               check("rst_data_valid", k, data_valid[k], 1'b0);
               check("rst_busy", k, busy[k], 1'b0);
               check("rst_word_done", k, word_done[k], 1'b0);
               check("rst_in_ready", k, in_ready[k], 1'b1);
            end else begin
               have    = (sb_wr[k] != sb_rd[k]);
               fr      = sb_mem[k][sb_rd[k] % QN];
               exp_rdy = (!have && gap_rem[k] == 0) ||
                         (gap_of(k) == 0 && have && fr[0] && bit_en);
               check("in_ready", k, in_ready[k], exp_rdy);
               check("data_valid", k, data_valid[k], have);
               check("data_out", k, data_out[k], have ? fr[1] : 1'b0);
               check("busy", k, busy[k], have || gap_rem[k] != 0);
               check("word_done", k, word_done[k], wd_exp[k]);
               wd_exp[k] = 1'b0;
               xfer = in_valid[k] && exp_rdy;
               if (gap_rem[k] > 0 && bit_en) gap_rem[k]--;
               if (have && bit_en) begin
                  sb_rd[k]++;
                  retired[k]++;
                  if (fr[0]) begin
                     wd_exp[k] = 1'b1;
                     if (!xfer) gap_rem[k] = gap_of(k);
                  end
               end
               if (xfer) push_word(k, in_data[k]);
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the rising edge of the transfer.
   task automatic send(input int k, input logic [W-1:0] d);
      int t;
      t = 0;
      in_valid[k] = 1'b1;
      in_data[k]  = d;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready[k] && t < 2000);
      if (t >= 2000) timeout_fail("send", k);
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
      in_data[k]  = W'($urandom);
   endtask

   task automatic producer(input int k, input int n);
      repeat (n) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         send(k, W'($urandom));
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (t < 3000 && !(sb_wr[0] == sb_rd[0] && sb_wr[1] == sb_rd[1] &&
                               gap_rem[0] == 0 && gap_rem[1] == 0));
      if (t >= 3000) timeout_fail("wait_idle", 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int t;
      rst_n = 1'b0;
      for (int k = 0; k < NI; k++) begin
         in_valid[k] = 1'b0;
         in_data[k]  = '0;
      end
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         check("idle_in_ready", k, in_ready[k], 1'b1);
         check("idle_data_out", k, data_out[k], 1'b0);
         check("idle_data_valid", k, data_valid[k], 1'b0);
         check("idle_busy", k, busy[k], 1'b0);
      end
      @(posedge clk);
      #1;

      // single word, continuous bit_en
      bit_mode = 0;
      fork
         send(0, 8'hA5);
         send(1, 8'h3C);
      join
      wait_idle();

      // paced bit_en
      bit_mode = 1;
      send(0, 8'h0F);
      wait_idle();

      // back-to-back on GAP=0, gap insertion on GAP=3
      bit_mode = 0;
      fork
         begin send(0, 8'h81); send(0, 8'h42); end
         begin send(1, 8'hFF); send(1, 8'hFF); end
      join
      wait_idle();

      // random words, random pacing, random upstream idles
      bit_mode = 2;
      fork
         producer(0, 150);
         producer(1, 150);
      join
      wait_idle();

      // reset mid-word
      bit_mode = 0;
      base = retired[0];
      send(0, 8'hB3);
      t = 0;
      while (retired[0] < base + 4 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) timeout_fail("mid_word", 0);
      @(posedge clk);
      #3;
      check("pre_rst_data_valid", 0, data_valid[0], 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_rst_data_valid", 0, data_valid[0], 1'b0);
      check("async_rst_data_out", 0, data_out[0], 1'b0);
      check("async_rst_busy", 0, busy[0], 1'b0);
      check("async_rst_in_ready", 0, in_ready[0], 1'b1);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      fork
         send(0, 8'hC6);
         send(1, 8'h5A);
      join
      wait_idle();

      for (int k = 0; k < NI; k++) check("scoreboard_drained", k, sb_wr[k] == sb_rd[k], 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout inst0: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
